impulse_mac: RTL and testbench
==============================

Name: impulse_mac

Overview:
- Convolution accumulator directly downstream of the memory controller.
- Consumes the alternating impulse-word / sample-word stream read from SRAM (or from off-chip memory) during one ADC frame.
- Multiply-accumulates each tap, adds the dry sample, and publishes one 16-bit reverb/delay output per frame to the DAC path.
- Also returns each decoded tap offset so the address generator can step its read pointer.

Parameters:
- MAX_TAPS, 511, hard cap on taps per frame; num_taps is clamped to this value.
- ACC_W, 32, accumulator width in bits (signed); must be at least 26.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-clk pulse, synchronised to clk, marking a new ADC frame.
- dry_in  input  16  signed dry sample; latched on frame_start.
- num_taps  input  11  number of taps to process this frame; latched on frame_start.
- mem_data  input  16  word returned by memory.
- mem_valid  input  1  mem_data is valid this cycle (one-cycle strobe per word).
- mem_is_impulse  input  1  1 = impulse word, 0 = sample word; qualified by mem_valid.
- busy  output  1  accumulating a frame.
- offset_valid  output  1  one-cycle pulse when an impulse word is accepted.
- tap_offset  output  7  {top[2:0], bottom[3:0]} decoded from the accepted impulse word.
- out_valid  output  1  one-cycle pulse; data_out updated.
- data_out  output  16  signed mixed output; holds its value between frames.
- seq_err  output  1  sticky; cleared on frame_start.
- overrun  output  1  one-cycle pulse when a frame is aborted by frame_start.

Behaviour:
- Reset values: all outputs 0, accumulator 0, state IDLE.
- Impulse word fields:
  - [15:13] top
  - [12:9] bottom
  - [8] neg
  - [7:0] mult (unsigned Q0.8, so 0x80 = 0.5)
  - 16'h0000 is the end-of-list terminator.
- States: IDLE, WAIT_IMP, WAIT_SMP, FINISH.
- IDLE:
  - On frame_start: latch dry_in; latch min(num_taps, MAX_TAPS); clear accumulator, tap count and seq_err; go to WAIT_IMP.
  - If the latched tap count is 0, go to FINISH instead.
- WAIT_IMP, on mem_valid with mem_is_impulse=1:
  - Terminator word: go to FINISH.
  - Otherwise: latch mult and neg, pulse offset_valid in the same cycle with tap_offset registered, and go to WAIT_SMP.
- WAIT_SMP, on mem_valid with mem_is_impulse=0:
  - product = signed(sample) * signed({1'b0, mult}), 25 bits.
  - acc += neg ? -product : product, with sign extension to ACC_W.
  - Tap count increments.
  - Go to FINISH when the count reaches the latched tap count; otherwise go to WAIT_IMP.
- Wrong word type for the current state: the word is dropped, seq_err is set, and the state is unchanged.
- mem_valid in IDLE or FINISH: ignored; no error is raised.
- FINISH:
  - sum = sext(dry) + (acc >>> 8), computed at 33 bits or more.
  - data_out <= result per the optional feature; out_valid pulses in the same cycle.
  - Go to IDLE.
  - Latency is one clk from the last accepted sample (or terminator) to out_valid.
- frame_start while busy (WAIT_IMP or WAIT_SMP):
  - Pulse overrun.
  - Publish the partial result exactly as FINISH would (out_valid pulses).
  - Restart for the new frame in the same cycle using the new dry_in and num_taps, going directly to WAIT_IMP, or to FINISH if the new tap count is 0.
- frame_start during FINISH: FINISH completes normally and the new frame starts in the same cycle.
- busy = 1 in WAIT_IMP and WAIT_SMP only.
- Asynchronous rst mid-frame: immediately returns to reset values; no out_valid is produced.

Optional Feature:
- Macro IMPULSE_MAC_SAT_EN.
- Defined: sum is saturated to 16-bit signed (0x7FFF / 0x8000), and the accumulator saturates at ACC_W limits instead of wrapping.
- Undefined: data_out = sum[15:0] (two's-complement wrap), and the accumulator wraps.

Test Plan:
- Single tap:
  - Stimulus: dry 0x1000, num_taps 1, impulse 0x0080, sample 0x2000.
  - Response: data_out 0x2000, out_valid one clk after the sample, tap_offset 0.
- Negative tap with offset:
  - Stimulus: dry 0x0000, impulse 0xA180 (top 5, bottom 0, neg 1, mult 0x80), sample 0x0400.
  - Response: tap_offset 7'h50, data_out 0xFE00.
- Saturation:
  - Stimulus: dry 0x7000, impulse 0x00FF, sample 0x7FFF.
  - Response: data_out 0x7FFF with IMPULSE_MAC_SAT_EN defined; 0xEF7F without it.
- Terminator:
  - Stimulus: num_taps 5, one valid tap (0x0080 / 0x0100), then impulse 0x0000.
  - Response: FINISH entered, data_out = dry + 0x0080, out_valid one clk after the terminator.
- Sequence error:
  - Stimulus: sample word while in WAIT_IMP.
  - Response: word dropped, seq_err = 1 until the next frame_start, accumulator unchanged.
- Overrun:
  - Stimulus: frame_start after 1 of 3 taps has been accumulated.
  - Response: overrun and out_valid pulse together with the partial result, busy stays 1, seq_err cleared, new dry value latched.

Source files
------------

// File: rtl/impulse_mac.sv
`default_nettype none
// ============================================================================
// Module   : impulse_mac
// Purpose  : Per-frame convolution MAC over the impulse/sample word stream;
//            publishes one 16-bit mixed output per ADC frame.
//            Optional macro IMPULSE_MAC_SAT_EN: saturating accumulator/output.
// Revision : 1.0  initial release
// ============================================================================
module impulse_mac #(
  parameter int MAX_TAPS = 511,
  parameter int ACC_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [15:0] dry_in,
  input  logic [10:0] num_taps,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  input  logic        mem_is_impulse,
  output logic        busy,
  output logic        offset_valid,
  output logic [6:0]  tap_offset,
  output logic        out_valid,
  output logic [15:0] data_out,
  output logic        seq_err,
  output logic        overrun
);

  localparam int         c_prod_w   = 25;
  localparam logic [10:0] c_max_taps = 11'(MAX_TAPS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IMP = 2'd1,
    WAIT_SMP = 2'd2,
    FINISH   = 2'd3
  } state_t;

  state_t                   r_state;
  logic [15:0]              r_dry;
  logic [10:0]              r_target;
  logic [10:0]              r_count;
  logic [7:0]               r_mult;
  logic                     r_neg;
  logic signed [ACC_W-1:0]  r_acc;

  logic [10:0]              w_taps_clamped;
  logic [10:0]              w_count_inc;
  logic signed [c_prod_w-1:0] w_sample_ext;
  logic signed [c_prod_w-1:0] w_mult_ext;
  logic signed [c_prod_w-1:0] w_product;
  logic signed [c_prod_w-1:0] w_term;
  logic signed [ACC_W-1:0]  w_term_ext;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [15:0]              w_result;

  assign w_taps_clamped = (num_taps > c_max_taps) ? c_max_taps : num_taps;
  assign w_count_inc    = r_count + 11'd1;

  // Signed sample times unsigned Q0.8 gain; magnitude always fits 25 bits.
  assign w_sample_ext = {{(c_prod_w-16){mem_data[15]}}, mem_data};
  assign w_mult_ext   = {{(c_prod_w-8){1'b0}}, r_mult};
  assign w_product    = w_sample_ext * w_mult_ext;
  assign w_term       = r_neg ? -w_product : w_product;
  assign w_term_ext   = {{(ACC_W-c_prod_w){w_term[c_prod_w-1]}}, w_term};

`ifdef IMPULSE_MAC_SAT_EN
  localparam int c_sum_w = ACC_W + 1;

  logic signed [ACC_W-1:0]   w_acc_add;
  logic                      w_acc_ovf;
  logic signed [ACC_W-1:0]   w_acc_shift;
  logic signed [c_sum_w-1:0] w_sum;
  logic                      w_in_range;

  assign w_acc_add  = r_acc + w_term_ext;
  assign w_acc_ovf  = (r_acc[ACC_W-1] == w_term_ext[ACC_W-1]) &&
                      (w_acc_add[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_acc_next = !w_acc_ovf ? w_acc_add :
                      (r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}});

  assign w_acc_shift = r_acc >>> 8;
  assign w_sum       = {{(c_sum_w-16){r_dry[15]}}, r_dry} +
                       {w_acc_shift[ACC_W-1], w_acc_shift};
  // In range when every bit from 15 upward matches the sign.
  assign w_in_range  = (&w_sum[c_sum_w-1:15]) | ~(|w_sum[c_sum_w-1:15]);
  assign w_result    = w_in_range ? w_sum[15:0]
                                  : (w_sum[c_sum_w-1] ? 16'h8000 : 16'h7FFF);
`else
  assign w_acc_next = r_acc + w_term_ext;
  // Low 16 bits of dry + (acc >>> 8) only need acc[23:8].
  assign w_result   = r_dry + r_acc[23:8];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_dry        <= '0;
      r_target     <= '0;
      r_count      <= '0;
      r_mult       <= '0;
      r_neg        <= 1'b0;
      r_acc        <= '0;
      busy         <= 1'b0;
      offset_valid <= 1'b0;
      tap_offset   <= '0;
      out_valid    <= 1'b0;
      data_out     <= '0;
      seq_err      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      offset_valid <= 1'b0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
      if (frame_start) begin
        // An in-flight or finishing frame publishes before the restart.
        if (r_state == WAIT_IMP || r_state == WAIT_SMP) begin
          overrun   <= 1'b1;
          out_valid <= 1'b1;
          data_out  <= w_result;
        end else if (r_state == FINISH) begin
          out_valid <= 1'b1;
          data_out  <= w_result;
        end
        r_dry    <= dry_in;
        r_target <= w_taps_clamped;
        r_acc    <= '0;
        r_count  <= '0;
        seq_err  <= 1'b0;
        if (w_taps_clamped == 11'd0) begin
          r_state <= FINISH;
          busy    <= 1'b0;
        end else begin
          r_state <= WAIT_IMP;
          busy    <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: ;
          WAIT_IMP: begin
            if (mem_valid) begin
              if (!mem_is_impulse) begin
                seq_err <= 1'b1;
              end else if (mem_data == 16'h0000) begin
                r_state <= FINISH;
                busy    <= 1'b0;
              end else begin
                r_mult       <= mem_data[7:0];
                r_neg        <= mem_data[8];
                tap_offset   <= {mem_data[15:13], mem_data[12:9]};
                offset_valid <= 1'b1;
                r_state      <= WAIT_SMP;
              end
            end
          end
          WAIT_SMP: begin
            if (mem_valid) begin
              if (mem_is_impulse) begin
                seq_err <= 1'b1;
              end else begin
                r_acc   <= w_acc_next;
                r_count <= w_count_inc;
                if (w_count_inc == r_target) begin
                  r_state <= FINISH;
                  busy    <= 1'b0;
                end else begin
                  r_state <= WAIT_IMP;
                end
              end
            end
          end
          FINISH: begin
            out_valid <= 1'b1;
            data_out  <= w_result;
            r_state   <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_impulse_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_impulse_mac
// Purpose  : Directed self-checking bench for impulse_mac.
// Revision : 1.0  initial release
// ============================================================================
module tb_impulse_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [15:0] dry_in;
  logic [10:0] num_taps;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        mem_is_impulse;
  logic        busy;
  logic        offset_valid;
  logic [6:0]  tap_offset;
  logic        out_valid;
  logic [15:0] data_out;
  logic        seq_err;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  impulse_mac dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .dry_in         (dry_in),
    .num_taps       (num_taps),
    .mem_data       (mem_data),
    .mem_valid      (mem_valid),
    .mem_is_impulse (mem_is_impulse),
    .busy           (busy),
    .offset_valid   (offset_valid),
    .tap_offset     (tap_offset),
    .out_valid      (out_valid),
    .data_out       (data_out),
    .seq_err        (seq_err),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [15:0] dry, input logic [10:0] taps);
    frame_start = 1'b1;
    dry_in      = dry;
    num_taps    = taps;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic word(input logic [15:0] d, input logic imp);
    mem_valid      = 1'b1;
    mem_data       = d;
    mem_is_impulse = imp;
    cyc();
    mem_valid      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; dry_in = '0; num_taps = '0;
    mem_data = '0; mem_valid = 1'b0; mem_is_impulse = 1'b0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_tap_offset", tap_offset, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    cyc();

    // Single tap: 0x2000 * 0.5 + 0x1000 = 0x2000
    start(16'h1000, 11'd1);
    chk("t1_busy", busy, 1);
    word(16'h0080, 1'b1);
    chk("t1_offset_valid", offset_valid, 1);
    chk("t1_tap_offset", tap_offset, 7'h00);
    word(16'h2000, 1'b0);
    chk("t1_no_early_out", out_valid, 0);
    chk("t1_busy_done", busy, 0);
    cyc();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_data_out", data_out, 16'h2000);
    cyc();
    chk("t1_out_pulse", out_valid, 0);
    chk("t1_hold", data_out, 16'h2000);

    // Negative tap with offset
    start(16'h0000, 11'd1);
    word(16'hA180, 1'b1);
    chk("t2_tap_offset", tap_offset, 7'h50);
    word(16'h0400, 1'b0);
    cyc();
    chk("t2_out_valid", out_valid, 1);
    chk("t2_data_out", data_out, 16'hFE00);

    // Output range limit
    start(16'h7000, 11'd1);
    word(16'h00FF, 1'b1);
    word(16'h7FFF, 1'b0);
    cyc();
    chk("t3_out_valid", out_valid, 1);
`ifdef IMPULSE_MAC_SAT_EN
    chk("t3_data_out", data_out, 16'h7FFF);
`else
    chk("t3_data_out", data_out, 16'hEF7F);
`endif

    // Terminator ends a 5-tap frame after one tap
    start(16'h0100, 11'd5);
    word(16'h0080, 1'b1);
    word(16'h0100, 1'b0);
    chk("t4_busy_mid", busy, 1);
    word(16'h0000, 1'b1);
    chk("t4_busy_term", busy, 0);
    chk("t4_no_early_out", out_valid, 0);
    chk("t4_no_offset", offset_valid, 0);
    cyc();
    chk("t4_out_valid", out_valid, 1);
    chk("t4_data_out", data_out, 16'h0180);

    // Sequence error: sample while waiting for impulse is dropped
    start(16'h0000, 11'd1);
    word(16'h1234, 1'b0);
    chk("t5_seq_err", seq_err, 1);
    chk("t5_busy", busy, 1);
    word(16'h0080, 1'b1);
    word(16'h0200, 1'b0);
    cyc();
    chk("t5_data_out", data_out, 16'h0100);
    chk("t5_seq_err_sticky", seq_err, 1);
    word(16'h5555, 1'b0);
    chk("t5_idle_ignored", seq_err, 1);
    chk("t5_idle_no_out", out_valid, 0);

    // Overrun after 1 of 3 taps, plus a seq error to be cleared
    start(16'h0010, 11'd3);
    chk("t6_seq_err_clr", seq_err, 0);
    word(16'h0080, 1'b1);
    word(16'h0200, 1'b0);
    word(16'h0999, 1'b0);
    chk("t6_seq_err_set", seq_err, 1);
    start(16'h0020, 11'd2);
    chk("t6_overrun", overrun, 1);
    chk("t6_out_valid", out_valid, 1);
    chk("t6_partial", data_out, 16'h0110);
    chk("t6_busy", busy, 1);
    chk("t6_seq_err_clr2", seq_err, 0);
    word(16'h0080, 1'b1);
    chk("t6_overrun_pulse", overrun, 0);
    word(16'h0400, 1'b0);
    word(16'h0080, 1'b1);
    word(16'h0400, 1'b0);
    cyc();
    chk("t6_new_data_out", data_out, 16'h0420);

    // Zero taps: straight to FINISH, output is the dry sample
    start(16'h1234, 11'd0);
    chk("t7_busy", busy, 0);
    chk("t7_no_early_out", out_valid, 0);
    cyc();
    chk("t7_out_valid", out_valid, 1);
    chk("t7_data_out", data_out, 16'h1234);

    // Tap count clamps to 511: 511 taps of 0x0100 * 1/256
    start(16'h0000, 11'd600);
    for (int i = 0; i < 511; i++) begin
      word(16'h0001, 1'b1);
      word(16'h0100, 1'b0);
    end
    chk("t8_busy_clamped", busy, 0);
    cyc();
    chk("t8_out_valid", out_valid, 1);
    chk("t8_data_out", data_out, 16'h01FF);

    // Asynchronous reset mid-frame
    start(16'h4000, 11'd2);
    word(16'hA180, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t9_async_busy", busy, 0);
    chk("t9_async_tap_offset", tap_offset, 0);
    chk("t9_async_data_out", data_out, 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("t9_no_out", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
